// File: rtl/cache_pkg.sv
// Shared definitions for the cache bank miss path: meta encodings, fill FSM
// states and the tree-pLRU helper functions.
package cache_pkg;

    localparam int DEF_TAG_SIZE = 20;
    localparam int DEF_INDEX_W  = 6;
    localparam int ADDR_W       = DEF_TAG_SIZE + DEF_INDEX_W;

    localparam logic [3:0] META_INVALID = 4'h1;
    localparam logic [3:0] META_CLEAN   = 4'h2;
    localparam logic [3:0] META_DIRTY   = 4'h3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_REQ,
        ST_WAIT,
        ST_FILL
    } fill_state_e;

    // Bits {b2,b1,b0} point toward the victim; touching a way points them away.
    function automatic logic [2:0] plru_touch(input logic [2:0] cur, input logic [3:0] way);
        logic [2:0] nxt;
        nxt = cur;
        if (way[0]) begin
            nxt[0] = 1'b1;
            nxt[1] = 1'b1;
        end else if (way[1]) begin
            nxt[0] = 1'b1;
            nxt[1] = 1'b0;
        end else if (way[2]) begin
            nxt[0] = 1'b0;
            nxt[2] = 1'b1;
        end else if (way[3]) begin
            nxt[0] = 1'b0;
            nxt[2] = 1'b0;
        end
        return nxt;
    endfunction

    function automatic logic [3:0] plru_victim(input logic [2:0] bits);
        logic [3:0] way;
        if (!bits[0]) begin
            way = bits[1] ? 4'b0010 : 4'b0001;
        end else begin
            way = bits[2] ? 4'b1000 : 4'b0100;
        end
        return way;
    endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree-pLRU storage with a combinational victim read port and two
// touch ports; the fill touch overrides a hit touch on the same set.
module cache_plru
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic [3:0]         victim_way_o,
    input  logic               fill_valid_i,
    input  logic [INDEX_W-1:0] fill_index_i,
    input  logic [3:0]         fill_way_i,
    input  logic               hit_valid_i,
    input  logic [INDEX_W-1:0] hit_index_i,
    input  logic [3:0]         hit_way_i
);

    localparam int SETS = 1 << INDEX_W;

    logic [2:0] plru_q [SETS];
    logic       hitOk;

    assign hitOk = hit_valid_i && $onehot(hit_way_i)
                   && !(fill_valid_i && (fill_index_i == hit_index_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= 3'b000;
            end
        end else begin
            if (hitOk) begin
                plru_q[hit_index_i] <= plru_touch(plru_q[hit_index_i], hit_way_i);
            end
            if (fill_valid_i) begin
                plru_q[fill_index_i] <= plru_touch(plru_q[fill_index_i], fill_way_i);
            end
        end
    end

    assign victim_way_o = plru_victim(plru_q[rd_index_i]);

endmodule

// File: rtl/tag_fill_ctrl.sv
// Miss-side tag-array writer for a 4-way bank: victim choice, dirty writeback,
// line request and tag/meta fill, plus ownership of the per-set pLRU state.
module tag_fill_ctrl
    import cache_pkg::*;
#(
    parameter int TAG_SIZE = DEF_TAG_SIZE,
    parameter int INDEX_W  = DEF_INDEX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        miss_valid,
    output logic                        miss_ready,
    input  logic [TAG_SIZE-1:0]         miss_tag,
    input  logic [INDEX_W-1:0]          miss_index,
    input  logic                        miss_write,
    input  logic                        hit_valid,
    input  logic [INDEX_W-1:0]          hit_index,
    input  logic [3:0]                  hit_way,
    output logic [INDEX_W-1:0]          rd_index,
    input  logic [TAG_SIZE*4-1:0]       tag_cur_state,
    input  logic [31:0]                 meta_in,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic [TAG_SIZE+INDEX_W-1:0] wb_addr,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [TAG_SIZE+INDEX_W-1:0] mem_req_addr,
    input  logic                        mem_resp_valid,
    output logic                        tag_we,
    output logic [INDEX_W-1:0]          tag_wr_index,
    output logic [3:0]                  tag_wr_way,
    output logic [TAG_SIZE-1:0]         tag_wr_data,
    output logic [7:0]                  meta_wr_data,
    output logic                        busy
);

    fill_state_e          state_q;
    logic [TAG_SIZE-1:0]  missTag_q;
    logic [INDEX_W-1:0]   index_q;
    logic                 write_q;
    logic [3:0]           vicWay_q;

    logic [3:0]           plruVictim;
    logic                 dupHit;
    logic                 invFound;
    logic [3:0]           invWay;
    logic [3:0]           vicWay;
    logic [TAG_SIZE-1:0]  vicTag;
    logic                 vicDirty;
    logic [TAG_SIZE-1:0]  wayTag;
    logic [3:0]           wayMeta;
    logic                 unusedMetaHi;

    assign unusedMetaHi = ^{meta_in[31:28], meta_in[23:20], meta_in[15:12], meta_in[7:4]};
    assign rd_index     = index_q;

    cache_plru #(
        .INDEX_W (INDEX_W)
    ) u_plru (
        .clk          (clk),
        .rst          (rst),
        .rd_index_i   (index_q),
        .victim_way_o (plruVictim),
        .fill_valid_i (state_q == ST_FILL),
        .fill_index_i (index_q),
        .fill_way_i   (vicWay_q),
        .hit_valid_i  (hit_valid),
        .hit_index_i  (hit_index),
        .hit_way_i    (hit_way)
    );

    // Only meaningful in LOOKUP, where rd_index has been presenting index_q.
    always_comb begin
        dupHit   = 1'b0;
        invFound = 1'b0;
        invWay   = 4'b0000;
        wayTag   = '0;
        wayMeta  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            wayTag  = tag_cur_state[TAG_SIZE*i +: TAG_SIZE];
            wayMeta = meta_in[8*i +: 4];
            if ((wayMeta != META_INVALID) && (wayTag == missTag_q)) begin
                dupHit = 1'b1;
            end
            if ((wayMeta == META_INVALID) && !invFound) begin
                invFound = 1'b1;
                invWay   = 4'(1 << i);
            end
        end
        vicWay   = invFound ? invWay : plruVictim;
        vicTag   = '0;
        vicDirty = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (vicWay[i]) begin
                vicTag   = tag_cur_state[TAG_SIZE*i +: TAG_SIZE];
                vicDirty = (meta_in[8*i +: 4] == META_DIRTY);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            missTag_q     <= '0;
            index_q       <= '0;
            write_q       <= 1'b0;
            vicWay_q      <= 4'b0000;
            miss_ready    <= 1'b1;
            busy          <= 1'b0;
            wb_valid      <= 1'b0;
            wb_addr       <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            tag_we        <= 1'b0;
            tag_wr_index  <= '0;
            tag_wr_way    <= 4'b0000;
            tag_wr_data   <= '0;
            meta_wr_data  <= 8'h00;
        end else begin
            tag_we <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (miss_valid) begin
                        missTag_q  <= miss_tag;
                        index_q    <= miss_index;
                        write_q    <= miss_write;
                        miss_ready <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (dupHit) begin
                        miss_ready <= 1'b1;
                        busy       <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        vicWay_q     <= vicWay;
                        mem_req_addr <= {missTag_q, index_q};
                        if (vicDirty) begin
                            wb_valid <= 1'b1;
                            wb_addr  <= {vicTag, index_q};
                            state_q  <= ST_WB;
                        end else begin
                            mem_req_valid <= 1'b1;
                            state_q       <= ST_REQ;
                        end
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        wb_valid      <= 1'b0;
                        mem_req_valid <= 1'b1;
                        state_q       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_q       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        tag_we       <= 1'b1;
                        tag_wr_index <= index_q;
                        tag_wr_way   <= vicWay_q;
                        tag_wr_data  <= missTag_q;
                        meta_wr_data <= {4'h0, (write_q ? META_DIRTY : META_CLEAN)};
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    miss_ready <= 1'b1;
                    busy       <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_fill_ctrl.sv
// Directed bench for tag_fill_ctrl: latency, victim choice, writeback stall,
// duplicate filtering, reset abort and same-cycle pLRU touch priority.
module tb_tag_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic        miss_ready;
    logic [19:0] miss_tag;
    logic [5:0]  miss_index;
    logic        miss_write;
    logic        hit_valid;
    logic [5:0]  hit_index;
    logic [3:0]  hit_way;
    logic [5:0]  rd_index;
    logic [79:0] tag_cur_state;
    logic [31:0] meta_in;
    logic        wb_valid;
    logic        wb_ready;
    logic [25:0] wb_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [25:0] mem_req_addr;
    logic        mem_resp_valid;
    logic        tag_we;
    logic [5:0]  tag_wr_index;
    logic [3:0]  tag_wr_way;
    logic [19:0] tag_wr_data;
    logic [7:0]  meta_wr_data;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;

    logic [3:0]  obsWay;
    logic [7:0]  obsMeta;
    logic        obsWb;
    logic [25:0] obsWbAddr;
    int          obsFill;
    int          activity;

    tag_fill_ctrl #(
        .TAG_SIZE (20),
        .INDEX_W  (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_valid     (miss_valid),
        .miss_ready     (miss_ready),
        .miss_tag       (miss_tag),
        .miss_index     (miss_index),
        .miss_write     (miss_write),
        .hit_valid      (hit_valid),
        .hit_index      (hit_index),
        .hit_way        (hit_way),
        .rd_index       (rd_index),
        .tag_cur_state  (tag_cur_state),
        .meta_in        (meta_in),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_addr        (wb_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .tag_we         (tag_we),
        .tag_wr_index   (tag_wr_index),
        .tag_wr_way     (tag_wr_way),
        .tag_wr_data    (tag_wr_data),
        .meta_wr_data   (meta_wr_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic setWays(input logic [19:0] t0, input logic [19:0] t1,
                           input logic [19:0] t2, input logic [19:0] t3,
                           input logic [7:0] m0, input logic [7:0] m1,
                           input logic [7:0] m2, input logic [7:0] m3);
        tag_cur_state = {t3, t2, t1, t0};
        meta_in       = {m3, m2, m1, m0};
    endtask

    task automatic pulseHit(input logic [5:0] idx, input logic [3:0] way);
        hit_valid = 1'b1;
        hit_index = idx;
        hit_way   = way;
        tick();
        hit_valid = 1'b0;
    endtask

    // Runs one miss with all readies high and the response held high; optionally
    // fires a hit touch in the same cycle as the fill touch.
    task automatic applyStimulus(input logic [19:0] t, input logic [5:0] idx, input logic wr,
                                 input logic fhEn, input logic [5:0] fhIdx, input logic [3:0] fhWay,
                                 output logic [3:0] wayOut, output logic [7:0] metaOut,
                                 output logic wbSeen, output logic [25:0] wbAddrOut,
                                 output int fillCycle);
        int cyc;
        bit done;
        wayOut    = 4'b0000;
        metaOut   = 8'h00;
        wbSeen    = 1'b0;
        wbAddrOut = '0;
        fillCycle = -1;
        mem_resp_valid = 1'b1;
        miss_tag   = t;
        miss_index = idx;
        miss_write = wr;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc < 30) begin
            hit_valid = 1'b0;
            if (wb_valid && !wbSeen) begin
                wbSeen    = 1'b1;
                wbAddrOut = wb_addr;
            end
            if (tag_we) begin
                wayOut    = tag_wr_way;
                metaOut   = meta_wr_data;
                fillCycle = cyc;
                if (fhEn) begin
                    hit_valid = 1'b1;
                    hit_index = fhIdx;
                    hit_way   = fhWay;
                end
            end
            if (!busy) begin
                done = 1'b1;
            end else begin
                tick();
                cyc++;
            end
        end
        hit_valid      = 1'b0;
        mem_resp_valid = 1'b0;
        checkOutput("missCompletes", 64'(done), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        miss_valid = 1'b0;
        miss_tag = '0;
        miss_index = '0;
        miss_write = 1'b0;
        hit_valid = 1'b0;
        hit_index = '0;
        hit_way = 4'b0000;
        wb_ready = 1'b1;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0;
        setWays(20'h0, 20'h0, 20'h0, 20'h0, 8'h01, 8'h01, 8'h01, 8'h01);
        repeat (3) tick();
        rst = 1'b0;

        checkOutput("rstMissReady", 64'(miss_ready), 64'd1);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstTagWe", 64'(tag_we), 64'd0);
        checkOutput("rstWbValid", 64'(wb_valid), 64'd0);
        checkOutput("rstReqValid", 64'(mem_req_valid), 64'd0);
        checkOutput("rstReqAddr", 64'(mem_req_addr), 64'd0);
        checkOutput("rstWrWay", 64'(tag_wr_way), 64'd0);
        tick();
        checkOutput("rstMissReadyAfter", 64'(miss_ready), 64'd1);

        // Clean read miss into an empty set, cycle by cycle.
        miss_tag = 20'h12345;
        miss_index = 6'd5;
        miss_write = 1'b0;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        checkOutput("c1Busy", 64'(busy), 64'd1);
        checkOutput("c1MissReady", 64'(miss_ready), 64'd0);
        checkOutput("c1RdIndex", 64'(rd_index), 64'd5);
        checkOutput("c1ReqValid", 64'(mem_req_valid), 64'd0);
        tick();
        checkOutput("c2ReqValid", 64'(mem_req_valid), 64'd1);
        checkOutput("c2ReqAddr", 64'(mem_req_addr), 64'({20'h12345, 6'd5}));
        checkOutput("c2WbValid", 64'(wb_valid), 64'd0);
        tick();
        checkOutput("c3ReqValid", 64'(mem_req_valid), 64'd0);
        checkOutput("c3TagWe", 64'(tag_we), 64'd0);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        checkOutput("c4TagWe", 64'(tag_we), 64'd1);
        checkOutput("c4WrWay", 64'(tag_wr_way), 64'b0001);
        checkOutput("c4WrData", 64'(tag_wr_data), 64'h12345);
        checkOutput("c4WrIndex", 64'(tag_wr_index), 64'd5);
        checkOutput("c4Meta", 64'(meta_wr_data), 64'h02);
        checkOutput("c4MissReady", 64'(miss_ready), 64'd0);
        tick();
        checkOutput("c5TagWe", 64'(tag_we), 64'd0);
        checkOutput("c5MissReady", 64'(miss_ready), 64'd1);
        checkOutput("c5Busy", 64'(busy), 64'd0);

        // Full clean set with reset pLRU picks way0.
        setWays(20'h00001, 20'h00002, 20'h00003, 20'h00004, 8'h02, 8'h02, 8'h02, 8'h02);
        applyStimulus(20'h00100, 6'd12, 1'b0, 1'b0, 6'd0, 4'b0000, obsWay, obsMeta, obsWb, obsWbAddr, obsFill);
        checkOutput("fullCleanWay", 64'(obsWay), 64'b0001);
        checkOutput("fullCleanNoWb", 64'(obsWb), 64'd0);
        checkOutput("fullCleanFillCycle", 64'(obsFill), 64'd4);

        // Hit on way0 moves the victim to way2.
        pulseHit(6'd13, 4'b0001);
        applyStimulus(20'h00200, 6'd13, 1'b0, 1'b0, 6'd0, 4'b0000, obsWay, obsMeta, obsWb, obsWbAddr, obsFill);
        checkOutput("hitWay0Victim", 64'(obsWay), 64'b0100);

        // Multi-hot and zero hit_way leave pLRU untouched.
        pulseHit(6'd14, 4'b0101);
        pulseHit(6'd14, 4'b0000);
        applyStimulus(20'h00300, 6'd14, 1'b0, 1'b0, 6'd0, 4'b0000, obsWay, obsMeta, obsWb, obsWbAddr, obsFill);
        checkOutput("badHitIgnored", 64'(obsWay), 64'b0001);

        // Store miss evicting a dirty way with a stalled writeback.
        setWays(20'hABCDE, 20'h11111, 20'h22222, 20'h33333, 8'h03, 8'h03, 8'h03, 8'h03);
        wb_ready = 1'b0;
        miss_tag = 20'h55555;
        miss_index = 6'd20;
        miss_write = 1'b1;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        tick();
        checkOutput("wbValid", 64'(wb_valid), 64'd1);
        checkOutput("wbAddr", 64'(wb_addr), 64'({20'hABCDE, 6'd20}));
        checkOutput("wbNoReqYet", 64'(mem_req_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("wbHoldValid", 64'(wb_valid), 64'd1);
            checkOutput("wbHoldAddr", 64'(wb_addr), 64'({20'hABCDE, 6'd20}));
            checkOutput("wbHoldNoReq", 64'(mem_req_valid), 64'd0);
        end
        wb_ready = 1'b1;
        tick();
        checkOutput("wbDoneValid", 64'(wb_valid), 64'd0);
        checkOutput("dirtyReqValid", 64'(mem_req_valid), 64'd1);
        checkOutput("dirtyReqAddr", 64'(mem_req_addr), 64'({20'h55555, 6'd20}));
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        checkOutput("dirtyTagWe", 64'(tag_we), 64'd1);
        checkOutput("dirtyWrWay", 64'(tag_wr_way), 64'b0001);
        checkOutput("dirtyMeta", 64'(meta_wr_data), 64'h03);
        tick();
        checkOutput("dirtyIdle", 64'(busy), 64'd0);
        miss_write = 1'b0;

        // Duplicate miss: way2 already holds the tag.
        setWays(20'h0, 20'h0, 20'h77777, 20'h0, 8'h01, 8'h01, 8'h02, 8'h01);
        miss_tag = 20'h77777;
        miss_index = 6'd30;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        activity = 0;
        for (int k = 0; k < 4; k++) begin
            if (wb_valid || mem_req_valid || tag_we) activity++;
            tick();
        end
        checkOutput("dupNoActivity", 64'(activity), 64'd0);
        checkOutput("dupIdleBusy", 64'(busy), 64'd0);
        checkOutput("dupIdleReady", 64'(miss_ready), 64'd1);

        // Matching tag in an INVALID way is not a duplicate; it is the victim.
        setWays(20'h00009, 20'h77777, 20'h0000A, 20'h0000B, 8'h02, 8'h01, 8'h02, 8'h02);
        applyStimulus(20'h77777, 6'd31, 1'b0, 1'b0, 6'd0, 4'b0000, obsWay, obsMeta, obsWb, obsWbAddr, obsFill);
        checkOutput("invalidMatchWay", 64'(obsWay), 64'b0010);

        // Reset while waiting for the response aborts the fill and clears pLRU.
        pulseHit(6'd41, 4'b0001);
        setWays(20'h0, 20'h0, 20'h0, 20'h0, 8'h01, 8'h01, 8'h01, 8'h01);
        miss_tag = 20'h44444;
        miss_index = 6'd40;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        tick();
        tick();
        checkOutput("waitBusy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortReady", 64'(miss_ready), 64'd1);
        checkOutput("abortTagWe", 64'(tag_we), 64'd0);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        checkOutput("lateRespTagWe", 64'(tag_we), 64'd0);
        checkOutput("lateRespBusy", 64'(busy), 64'd0);
        tick();
        checkOutput("lateRespTagWe2", 64'(tag_we), 64'd0);
        setWays(20'h00001, 20'h00002, 20'h00003, 20'h00004, 8'h02, 8'h02, 8'h02, 8'h02);
        applyStimulus(20'h00400, 6'd41, 1'b0, 1'b0, 6'd0, 4'b0000, obsWay, obsMeta, obsWb, obsWbAddr, obsFill);
        checkOutput("plruCleared", 64'(obsWay), 64'b0001);

        // Fill touch of way1 and hit touch of way3 on the same set: fill wins.
        pulseHit(6'd9, 4'b0100);
        setWays(20'h00001, 20'h00002, 20'h00003, 20'h00004, 8'h02, 8'h01, 8'h02, 8'h02);
        applyStimulus(20'h00500, 6'd9, 1'b0, 1'b1, 6'd9, 4'b1000, obsWay, obsMeta, obsWb, obsWbAddr, obsFill);
        checkOutput("sameSetFillWay", 64'(obsWay), 64'b0010);
        setWays(20'h00001, 20'h00500, 20'h00003, 20'h00004, 8'h02, 8'h02, 8'h02, 8'h02);
        applyStimulus(20'h00600, 6'd9, 1'b0, 1'b0, 6'd0, 4'b0000, obsWay, obsMeta, obsWb, obsWbAddr, obsFill);
        checkOutput("sameSetFillWins", 64'(obsWay), 64'b1000);

        // Fill and hit on different sets both take effect.
        setWays(20'h0, 20'h0, 20'h0, 20'h0, 8'h01, 8'h01, 8'h01, 8'h01);
        applyStimulus(20'h00700, 6'd50, 1'b0, 1'b1, 6'd51, 4'b0001, obsWay, obsMeta, obsWb, obsWbAddr, obsFill);
        checkOutput("diffSetFillWay", 64'(obsWay), 64'b0001);
        setWays(20'h00001, 20'h00002, 20'h00003, 20'h00004, 8'h02, 8'h02, 8'h02, 8'h02);
        applyStimulus(20'h00800, 6'd51, 1'b0, 1'b0, 6'd0, 4'b0000, obsWay, obsMeta, obsWb, obsWbAddr, obsFill);
        checkOutput("diffSetHitApplied", 64'(obsWay), 64'b0100);
        checkOutput("diffSetMeta", 64'(obsMeta), 64'h02);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
